// File: rtl/compute_scheduler.sv
// compute_scheduler: front-end sequencer for the matrix computation block.
// For each job it pulses the operand-load strobe, waits for the load to
// complete, then holds one engine-active strobe (single PE, 3x3 or 2x2
// systolic array) until that engine reports done. It then latches the 2x2
// result and returns a one-cycle done (with err for an illegal mode).
//
// Optional build macro: COMP_TIMEOUT_EN
//   When defined, WAIT_SEND and RUN give up after TIMEOUT_CYCLES cycles
//   and finish the job with err. When undefined, both states wait forever.
module compute_scheduler #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,            // asynchronous, active low
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             active_send,
    output logic             active_single,
    output logic             active_sa3,
    output logic             active_sa2,
    input  logic             done_send,
    input  logic             done_single,
    input  logic             done_sa3,
    input  logic             done_sa2,
    input  logic [7:0]       c11_in,
    input  logic [7:0]       c12_in,
    input  logic [7:0]       c21_in,
    input  logic [7:0]       c22_in,
    output logic [7:0]       r11,
    output logic [7:0]       r12,
    output logic [7:0]       r21,
    output logic [7:0]       r22,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_SEND,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_SINGLE  = 2'd0;
    localparam logic [1:0] MODE_SA3     = 2'd1;
    localparam logic [1:0] MODE_SA2     = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
    logic [7:0]       r11_q, r12_q, r21_q, r22_q;
    logic             sel_done;
    logic             capture;

    // Saturating increment of the cycle counter.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Done flag of the engine picked by the latched mode; the others are ignored.
    always_comb begin
        sel_done = 1'b0;
        case (mode_q)
            MODE_SINGLE: sel_done = done_single;
            MODE_SA3:    sel_done = done_sa3;
            MODE_SA2:    sel_done = done_sa2;
            default:     sel_done = 1'b0;
        endcase
    end

    // Next-state logic for the job sequencer and its bookkeeping registers.
    always_comb begin
        // NOTE: every signal gets a default before the case statement so that
        // no branch leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        mode_d       = mode_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        run_cycles_d = run_cycles_q;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_ILLEGAL) begin
                        // No engine is touched; results stay as they are.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        mode_d  = mode;
                        state_d = ST_SEND;
                    end
                end
            end

            ST_SEND: begin
                cnt_d   = '0;
                state_d = ST_WAIT_SEND;
            end

            ST_WAIT_SEND: begin
                if (done_send) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
`ifdef COMP_TIMEOUT_EN
                else if (cnt_inc == TIMEOUT_VAL) begin
                    err_d        = 1'b1;
                    run_cycles_d = TIMEOUT_VAL;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end

            ST_RUN: begin
                cnt_d = cnt_inc;
                if (sel_done) begin
                    // The result bus is only valid while the strobe is high,
                    // so it is captured on the very cycle done is seen.
                    capture      = 1'b1;
                    run_cycles_d = cnt_inc;
                    state_d      = ST_DONE;
                end
`ifdef COMP_TIMEOUT_EN
                else if (cnt_inc == TIMEOUT_VAL) begin
                    err_d        = 1'b1;
                    run_cycles_d = TIMEOUT_VAL;
                    state_d      = ST_DONE;
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifndef COMP_TIMEOUT_EN
    // Without the timeout the limit is never compared; keep it referenced.
    logic unused_timeout_val;
    assign unused_timeout_val = ^TIMEOUT_VAL;
`endif

    // State and control registers; reset abandons any job without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_SINGLE;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            run_cycles_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q      <= state_d;
            mode_q       <= mode_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // Result registers: hold until the next successful capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r11_q <= '0;
            r12_q <= '0;
            r21_q <= '0;
            r22_q <= '0;
        end else if (capture) begin
            r11_q <= c11_in;
            r12_q <= c12_in;
            r21_q <= c21_in;
            r22_q <= c22_in;
        end
    end

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops them immediately and at most one can be high at a time.
    assign active_send   = (state_q == ST_SEND);
    assign active_single = (state_q == ST_RUN) && (mode_q == MODE_SINGLE);
    assign active_sa3    = (state_q == ST_RUN) && (mode_q == MODE_SA3);
    assign active_sa2    = (state_q == ST_RUN) && (mode_q == MODE_SA2);

    assign busy = (state_q == ST_SEND) || (state_q == ST_WAIT_SEND) ||
                  (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign err  = (state_q == ST_DONE) && err_q;

    assign r11        = r11_q;
    assign r12        = r12_q;
    assign r21        = r21_q;
    assign r22        = r22_q;
    assign run_cycles = run_cycles_q;

endmodule
